traffic_light_ctrl: RTL and testbench

//  Pedestrian-crossing traffic-light FSM, clocked by the system clk, advanced by one divided clock from clk_wiz.
//  A rising edge of tick_src (e.g. clk_div_500) yields a one-cycle enable; all durations are counted in those ticks.
//  A pedestrian button request stops car traffic after a minimum car-green time. Drives the lamp outputs on the board.

---
 rtl/traffic_light_ctrl_pkg.sv | 23 ++
 rtl/traffic_light_ctrl_rise_detect.sv | 21 ++
 rtl/traffic_light_ctrl.sv | 125 ++++++++++++
 tb/tb_traffic_light_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_ctrl_pkg.sv
// Shared types for the pedestrian-crossing controller: FSM state encoding and lamp bundle.
package traffic_light_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_CAR_GREEN  = 3'd0,
        ST_CAR_YELLOW = 3'd1,
        ST_ALL_RED_1  = 3'd2,
        ST_PED_GREEN  = 3'd3,
        ST_PED_BLINK  = 3'd4,
        ST_ALL_RED_2  = 3'd5
    } state_e;

    typedef struct packed {
        logic car_red;
        logic car_yellow;
        logic car_green;
        logic ped_red;
        logic ped_green;
    } lamps_t;

endpackage

// File: rtl/traffic_light_ctrl_rise_detect.sv
// Rising-edge detector: one-cycle pulse on a 0->1 transition of a clk-synchronous input.
module traffic_light_ctrl_rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise_c
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise_c = d & ~d_q;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Pedestrian-crossing traffic-light controller; all durations counted in rising edges of tick_src.
module traffic_light_ctrl
    import traffic_light_ctrl_pkg::*;
#(
    parameter int unsigned TW          = 4,
    parameter int unsigned T_GREEN_MIN = 8,
    parameter int unsigned T_YELLOW    = 3,
    parameter int unsigned T_ALLRED    = 1,
    parameter int unsigned T_PED       = 6,
    parameter int unsigned T_BLINK     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_src,
    input  logic ped_btn,
    output logic car_red,
    output logic car_yellow,
    output logic car_green,
    output logic ped_red,
    output logic ped_green,
    output logic ped_wait
);

    localparam logic [TW-1:0] TIMER_MAX    = '1;
    localparam logic [TW-1:0] GREEN_LAST   = TW'(T_GREEN_MIN - 1);
    localparam logic [TW-1:0] YELLOW_LAST  = TW'(T_YELLOW - 1);
    localparam logic [TW-1:0] ALLRED_LAST  = TW'(T_ALLRED - 1);
    localparam logic [TW-1:0] PED_LAST     = TW'(T_PED - 1);
    localparam logic [TW-1:0] BLINK_LAST   = TW'(T_BLINK - 1);

    state_e          state;
    state_e          state_nxt;
    logic [TW-1:0]   timer;
    logic            tick_en;
    logic            btn_meta;
    logic            btn_sync;
    logic            req;
    logic            enter_ped;
    lamps_t          lamps;

    traffic_light_ctrl_rise_detect u_tick_rise (
        .clk    (clk),
        .rst_n  (rst),
        .d      (tick_src),
        .rise_c (tick_en)
    );

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= ped_btn;
            btn_sync <= btn_meta;
        end
    end

    assign enter_ped = (state_nxt == ST_PED_GREEN) && (state != ST_PED_GREEN);

    // Request latch; serving the request wins over a press on the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req <= 1'b0;
        end else if (enter_ped) begin
            req <= 1'b0;
        end else if (btn_sync) begin
            req <= 1'b1;
        end
    end

    // Per-state tick counter, saturating so an idle green never wraps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
        end else if (state_nxt != state) begin
            timer <= '0;
        end else if (tick_en && (timer != TIMER_MAX)) begin
            timer <= timer + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_CAR_GREEN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CAR_GREEN:  if (tick_en && req && (timer >= GREEN_LAST)) state_nxt = ST_CAR_YELLOW;
            ST_CAR_YELLOW: if (tick_en && (timer == YELLOW_LAST))       state_nxt = ST_ALL_RED_1;
            ST_ALL_RED_1:  if (tick_en && (timer == ALLRED_LAST))       state_nxt = ST_PED_GREEN;
            ST_PED_GREEN:  if (tick_en && (timer == PED_LAST))          state_nxt = ST_PED_BLINK;
            ST_PED_BLINK:  if (tick_en && (timer == BLINK_LAST))        state_nxt = ST_ALL_RED_2;
            ST_ALL_RED_2:  if (tick_en && (timer == ALLRED_LAST))       state_nxt = ST_CAR_GREEN;
            default:       state_nxt = ST_CAR_GREEN;
        endcase
    end

    // Moore lamp decode; blink starts lit on even timer values
    always_comb begin
        lamps = '0;
        case (state)
            ST_CAR_GREEN:  begin lamps.car_green  = 1'b1; lamps.ped_red = 1'b1; end
            ST_CAR_YELLOW: begin lamps.car_yellow = 1'b1; lamps.ped_red = 1'b1; end
            ST_ALL_RED_1,
            ST_ALL_RED_2:  begin lamps.car_red    = 1'b1; lamps.ped_red = 1'b1; end
            ST_PED_GREEN:  begin lamps.car_red    = 1'b1; lamps.ped_green = 1'b1; end
            ST_PED_BLINK:  begin lamps.car_red    = 1'b1; lamps.ped_green = ~timer[0]; end
            default:       begin lamps.car_green  = 1'b1; lamps.ped_red = 1'b1; end
        endcase
    end

    assign car_red    = lamps.car_red;
    assign car_yellow = lamps.car_yellow;
    assign car_green  = lamps.car_green;
    assign ped_red    = lamps.ped_red;
    assign ped_green  = lamps.ped_green;
    assign ped_wait   = req;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl: phase-table reference model feeds a queue, negedge monitor checks.
module tb_traffic_light_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic tick_src;
    logic ped_btn;
    logic car_red, car_yellow, car_green, ped_red, ped_green, ped_wait;

    traffic_light_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .tick_src   (tick_src),
        .ped_btn    (ped_btn),
        .car_red    (car_red),
        .car_yellow (car_yellow),
        .car_green  (car_green),
        .ped_red    (ped_red),
        .ped_green  (ped_green),
        .ped_wait   (ped_wait)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [5:0] exp_q[$];

    // Reference model: phase index into a duration table plus ticks elapsed in the phase
    int dur[6] = '{8, 3, 1, 6, 4, 1};
    int ph = 0;
    int el = 0;
    bit m_req = 0;
    bit m_prev = 0;
    bit dly[2] = '{0, 0};
    bit m_tick, m_sync, m_enter, m_done;

    function automatic logic [5:0] model_lamps();
        bit cg, cy, cr, pr, pg;
        cg = (ph == 0);
        cy = (ph == 1);
        cr = (ph >= 2);
        pr = (ph <= 2) || (ph == 5);
        pg = (ph == 3) || ((ph == 4) && (el % 2 == 0));
        return {cr, cy, cg, pr, pg, m_req};
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            ph = 0; el = 0; m_req = 0; m_prev = 0; dly[0] = 0; dly[1] = 0;
        end else begin
            m_tick  = tick_src && !m_prev;
            m_prev  = tick_src;
            m_sync  = dly[1];
            dly[1]  = dly[0];
            dly[0]  = ped_btn;
            m_enter = 0;
            if (m_tick) begin
                m_done = (ph == 0) ? (m_req && (el >= dur[0] - 1)) : (el == dur[ph] - 1);
                if (m_done) begin
                    ph = (ph + 1) % 6;
                    el = 0;
                    m_enter = (ph == 3);
                end else if (el < 15) begin
                    el = el + 1;
                end
            end
            if (m_enter)     m_req = 0;
            else if (m_sync) m_req = 1;
            exp_q.push_back(model_lamps());
        end
    end

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%b want=%b (cr cy cg pr pg wait)", name, $time, act, exp);
        end
    endtask

    logic [5:0] act_v;
    int car_sum, ped_sum;

    always @(negedge clk) begin
        act_v = {car_red, car_yellow, car_green, ped_red, ped_green, ped_wait};
        if (!rst || exp_q.size() == 0) begin
            exp_q.delete();
            check("reset_state", act_v, 6'b001100);
        end else begin
            check("lamps", act_v, exp_q.pop_front());
        end
        car_sum = int'(car_red) + int'(car_yellow) + int'(car_green);
        ped_sum = int'(ped_red) + int'(ped_green);
        total++;
        if (car_sum != 1 || !(ped_sum == 1 || (ped_sum == 0 && ph == 4))) begin
            bad++;
            $display("FAIL lamp_exclusive t=%0t car_lit=%0d ped_lit=%0d want car=1 ped=1", $time, car_sum, ped_sum);
        end
    end

    int  tcnt = 0;
    bit  stuck = 0;
    bit  stuck_val = 0;

    task automatic step(input bit btn);
        @(posedge clk);
        #2;
        ped_btn = btn;
        if (stuck) begin
            tick_src = stuck_val;
        end else begin
            tick_src = (tcnt % 4 == 0);
            tcnt++;
        end
    endtask

    task automatic run(input int n, input bit btn);
        for (int i = 0; i < n; i++) step(btn);
    endtask

    task automatic set_rst(input bit v);
        @(posedge clk);
        #2;
        rst = v;
    endtask

    int w;

    initial begin
        rst = 1'b0; tick_src = 1'b0; ped_btn = 1'b0;

        // reset with random inputs, then long idle
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #2;
            ped_btn  = 1'($urandom);
            tick_src = 1'($urandom);
        end
        set_rst(1'b1);
        tick_src = 1'b0; ped_btn = 1'b0;
        run(80, 1'b0);

        // single press early, then long idle press, then held button
        run(8, 1'b0);
        step(1'b1);
        run(150, 1'b0);
        run(100, 1'b0);
        step(1'b1);
        run(150, 1'b0);
        run(200, 1'b1);
        run(150, 1'b0);

        // random presses with occasional stuck tick_src windows
        for (int i = 0; i < 1500; i++) begin
            stuck     = (i % 300) >= 270;
            stuck_val = 1'((i / 300) % 2);
            step($urandom_range(0, 39) == 0);
        end
        stuck = 0;

        // reset in the middle of pedestrian green, then tick_src stuck high
        step(1'b1);
        w = 0;
        while (ph != 3 && w < 400) begin
            step(1'b0);
            w++;
        end
        total++;
        if (ph != 3) begin
            bad++;
            $display("FAIL ped_green_wait got_phase=%0d want_phase=3 after %0d clks", ph, w);
        end
        run(6, 1'b0);
        stuck = 1; stuck_val = 1;
        set_rst(1'b0);
        tick_src = 1'b1;
        run(3, 1'b1);
        set_rst(1'b1);
        for (int i = 0; i < 50; i++) step(1'($urandom));
        stuck = 0;
        run(150, 1'b0);
        run(2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
